spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised SPI master, the successor to the fixed 8-bit spi shift-register block. It adds configurable word width, all four SPI modes selected per transfer, a programmable SCLK divider, multiple chip selects, selectable bit order and a start/busy/done handshake. It sits between a local control FSM or register interface and one or more external SPI slaves.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 4, SCLK half-period in clk cycles (>=1; SCLK = clk/(2*CLK_DIV))
NUM_CS, 1, number of active-low chip-select outputs (>=1)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
CS_W, max(1,$clog2(NUM_CS)), derived width of cs_sel

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a transfer; accepted only in IDLE
tx_data  in  DATA_W  word to transmit; latched on accept
cs_sel  in  CS_W  index of chip select to assert; latched on accept
cpol  in  1  SCLK idle level; latched on accept
cpha  in  1  clock phase; latched on accept
busy  out  1  high from accept until the done cycle (exclusive)
done  out  1  one-cycle pulse when the transfer completes
rx_data  out  DATA_W  received word; updated in the done cycle, held otherwise
sclk  out  1  SPI serial clock
mosi  out  1  serial data out
miso  in  1  serial data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; sclk=0, mosi=0, cs_n all 1, busy=0, done=0, rx_data=0, latched cpol/cpha=0, divider and bit counters 0. Reset applies mid-transfer: abort immediately, no done pulse.
- FSM states: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
- IDLE: sclk = latched cpol. When start=1, latch inputs, go to SETUP. busy=1 and cs_n[cs_sel]=0 take effect next cycle. mosi presents the first bit (tx_data MSB or LSB per MSB_FIRST).
- SETUP: lasts CLK_DIV cycles; no SCLK edges.
- TRANSFER: lasts 2*DATA_W*CLK_DIV cycles. sclk toggles every CLK_DIV cycles, giving 2*DATA_W edges. Odd-numbered edges are leading, even-numbered edges trailing.
  - cpha=0: sample miso on leading edges; shift next bit onto mosi on trailing edges, except the final trailing edge.
  - cpha=1: shift on leading edges (first leading edge presents bit 0 of the sequence); sample on trailing edges.
- HOLD: lasts CLK_DIV cycles; sclk at idle level; cs_n still asserted.
- End of HOLD: state IDLE, cs_n all 1, busy=0, done=1 for exactly one cycle, rx_data = assembled word (first received bit lands in MSB if MSB_FIRST=1, else in LSB).
- Latency: done rises CLK_DIV*(2*DATA_W+2) cycles after cs_n falls (72 for defaults).
- start while busy: ignored, no queueing. Input changes during a transfer are ignored.
- start asserted in the done cycle: accepted (state is IDLE). cs_n deasserts for exactly one cycle between words.
- cs_sel >= NUM_CS: transfer runs normally, all cs_n stay 1, done still pulses.
- Changed cpol on accept: sclk moves to the new idle level in the cycle after accept, before any edge.
- mosi holds its last value after the transfer until the next accept.

Test Plan:
- Defaults, mode 0, miso looped to mosi, tx_data=0xA5 -> exactly 8 rising sclk edges; rx_data=0xA5; done pulses once, 72 cycles after cs_n[0] falls; busy=0 with done.
- Mode 3 (cpol=1,cpha=1), slave model returns 0x3C, tx_data=0xC3 -> sclk idles high; mosi bits change on falling edges and read 1,1,0,0,0,0,1,1; rx_data=0x3C.
- MSB_FIRST=0, DATA_W=16, NUM_CS=4, CLK_DIV=1, cs_sel=2, tx_data=0x8001 -> only cs_n[2] low; mosi sequence starts 1,0,0…, ends with 1; done 34 cycles after cs_n falls.
- start pulsed again mid-transfer with different tx_data -> ignored; original word completes unchanged; exactly one done pulse.
- rst=1 at sclk edge 5 of a transfer -> next cycle: cs_n all 1, sclk=0, busy=0; no done pulse; a new start then completes correctly.
- start held high through done, two words 0x11 then 0x22 -> cs_n high for exactly one cycle between transfers; rx_data=0x11 then 0x22 in loopback.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with a start/busy/done handshake.
// Supports all four SPI modes, selected on each transfer, and a programmable
// SCLK divider. It drives several active-low chip selects and can shift
// either bit order.
//
// Parameters:
//   DATA_W    bits per transfer (>=2)
//   CLK_DIV   SCLK half-period in clk cycles (>=1)
//   NUM_CS    number of chip-select outputs (>=1)
//   MSB_FIRST 1 = MSB shifted first, 0 = LSB first
//   CS_W      width of cs_sel (derived)
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   start            transfer request, accepted only while idle
//   tx_data, cs_sel  word and chip-select index, latched on accept
//   cpol, cpha       SPI mode, latched on accept
//   busy, done       busy from accept until the done cycle; done is a 1-cycle pulse
//   rx_data          received word, updated in the done cycle
//   sclk, mosi, miso SPI serial clock and data lines
//   cs_n             active-low chip selects
module spi_master_param #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter int NUM_CS    = 1,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGES  = 2 * DATA_W;
   localparam int EDGE_W = $clog2(EDGES);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
   localparam int unsigned       NCS       = NUM_CS;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      TRANSFER,
      HOLD
   } state_t;

   state_t state, state_next;

   logic [DIV_W-1:0]  div_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic              cpol_q;
   logic              cpha_q;

   logic              tick;
   logic              accept;
   logic              sclk_edge;
   logic              finish;
   logic              leading;
   logic              shift_now;
   logic              sample_now;
   logic              first_bit;
   logic [NUM_CS-1:0] cs_dec;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cycle strobes
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      sclk_edge  = 1'b0;
      finish     = 1'b0;
      tick       = (div_cnt == DIV_LAST);
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               state_next = TRANSFER;
            end
         end
         TRANSFER: begin
            if (tick) begin
               sclk_edge = 1'b1;
               if (edge_cnt == EDGE_LAST) begin
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Edge classification. edge_cnt holds the number of edges already made, so an
   // even count means the coming edge is a leading (odd-numbered) one. The first
   // bit is placed on mosi at accept. That makes mode-1/3's first leading edge and
   // mode-0/2's last trailing edge no-shift edges, leaving DATA_W-1 shifts.
   always_comb begin
      leading    = ~edge_cnt[0];
      shift_now  = 1'b0;
      sample_now = 1'b0;
      if (sclk_edge) begin
         if (cpha_q) begin
            shift_now  = leading & (edge_cnt != '0);
            sample_now = ~leading;
         end else begin
            shift_now  = ~leading & (edge_cnt != EDGE_LAST);
            sample_now = leading;
         end
      end
   end

   // Chip-select decode; an out-of-range index leaves every select deasserted
   always_comb begin
      cs_dec = '1;
      for (int unsigned i = 0; i < NCS; i++) begin
         if (cs_sel == CS_W'(i)) begin
            cs_dec[i] = 1'b0;
         end
      end
   end

   assign first_bit = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         cs_n     <= '1;
      end else begin
         done <= 1'b0;

         if (state == IDLE || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (accept) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            sclk     <= cpol;
            busy     <= 1'b1;
            cs_n     <= cs_dec;
            mosi     <= first_bit;
            tx_sh    <= MSB_FIRST ? (tx_data << 1) : (tx_data >> 1);
            rx_sh    <= '0;
            edge_cnt <= '0;
         end

         if (sclk_edge) begin
            sclk     <= ~sclk;
            edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + EDGE_W'(1);
         end

         if (shift_now) begin
            mosi  <= MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
            tx_sh <= MSB_FIRST ? (tx_sh << 1) : (tx_sh >> 1);
         end

         if (sample_now) begin
            rx_sh <= MSB_FIRST ? {rx_sh[DATA_W-2:0], miso} : {miso, rx_sh[DATA_W-1:1]};
         end

         if (finish) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            cs_n    <= '1;
            rx_data <= rx_sh;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed bench for spi_master_param.
// dut_a uses default parameters (8-bit, CLK_DIV=4, one chip select, MSB first).
// dut_b is 16-bit with CLK_DIV=1, four chip selects and LSB first.
// Ports: none (top-level bench).
module tb_spi_master_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // dut_a: default parameters
   logic       start_a, cpol_a, cpha_a, busy_a, done_a, sclk_a, mosi_a, miso_a;
   logic [7:0] tx_a, rx_a;
   logic [0:0] cs_sel_a, cs_n_a;
   bit         loop_a;
   logic       slave_a;
   assign miso_a = loop_a ? mosi_a : slave_a;

   spi_master_param dut_a (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a),
      .tx_data (tx_a),
      .cs_sel  (cs_sel_a),
      .cpol    (cpol_a),
      .cpha    (cpha_a),
      .busy    (busy_a),
      .done    (done_a),
      .rx_data (rx_a),
      .sclk    (sclk_a),
      .mosi    (mosi_a),
      .miso    (miso_a),
      .cs_n    (cs_n_a)
   );

   // dut_b: 16-bit, LSB first, four chip selects, fastest divider, loopback
   logic        start_b, busy_b, done_b, sclk_b, mosi_b;
   logic [15:0] tx_b, rx_b;
   logic [1:0]  cs_sel_b;
   logic [3:0]  cs_n_b;

   spi_master_param #(
      .DATA_W    (16),
      .CLK_DIV   (1),
      .NUM_CS    (4),
      .MSB_FIRST (1'b0)
   ) dut_b (
      .clk     (clk),
      .rst     (rst),
      .start   (start_b),
      .tx_data (tx_b),
      .cs_sel  (cs_sel_b),
      .cpol    (1'b0),
      .cpha    (1'b0),
      .busy    (busy_b),
      .done    (done_b),
      .rx_data (rx_b),
      .sclk    (sclk_b),
      .mosi    (mosi_b),
      .miso    (mosi_b),
      .cs_n    (cs_n_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Results of the most recent run_a
   int         r_lat, r_rises, r_falls, r_done, r_mosi_bad, r_cs_low;
   logic [7:0] r_mosi, r_rx;
   logic       r_sclk0, r_busy0, r_csn0, r_busy_done, r_sclk_done;

   // One transfer on dut_a, observed one cycle at a time from the accept edge.
   // In slave mode, the bench model shifts sw out MSB first on each leading edge.
   // A nonzero restart_at pulses start again with different data at that cycle.
   task automatic run_a(input logic [7:0] tx, input logic cp, input logic ch,
                        input logic [0:0] cs, input bit loop, input logic [7:0] sw,
                        input int restart_at);
      logic prev_sclk, prev_mosi;
      int   lead;
      r_lat = -1; r_rises = 0; r_falls = 0; r_done = 0; r_mosi_bad = 0; r_cs_low = 0;
      r_mosi = '0; r_rx = '0; r_busy_done = 1'b1; r_sclk_done = 1'bx;
      lead = 0;
      loop_a = loop; slave_a = 1'b0;
      tx_a = tx; cpol_a = cp; cpha_a = ch; cs_sel_a = cs; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      r_sclk0 = sclk_a; r_busy0 = busy_a; r_csn0 = cs_n_a[0];
      prev_sclk = sclk_a; prev_mosi = mosi_a;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         start_a = 1'b0;
         if (c == restart_at) begin
            start_a = 1'b1;
            tx_a    = ~tx;
            cpol_a  = ~cp;
            cpha_a  = ~ch;
         end
         if (cs_n_a[0] == 1'b0) r_cs_low++;
         if (sclk_a != prev_sclk) begin
            if (sclk_a) begin
               r_rises++;
               r_mosi = {r_mosi[6:0], mosi_a};
            end else begin
               r_falls++;
            end
            if (sclk_a != cp) begin
               if (lead < 8) slave_a = sw[7-lead];
               lead++;
            end
         end
         if (mosi_a != prev_mosi && !(prev_sclk == 1'b1 && sclk_a == 1'b0)) r_mosi_bad++;
         if (done_a) begin
            r_done++;
            if (r_lat < 0) begin
               r_lat       = c;
               r_busy_done = busy_a;
               r_rx        = rx_a;
               r_sclk_done = sclk_a;
            end
         end
         prev_sclk = sclk_a;
         prev_mosi = mosi_a;
         if (r_lat >= 0 && c >= r_lat + 6) break;
      end
   endtask

   initial begin
      int          edges, cnt, got, lat;
      logic        prev;
      logic [15:0] rec_b;

      rst = 1'b1;
      start_a = 1'b0; tx_a = '0; cs_sel_a = '0; cpol_a = 1'b0; cpha_a = 1'b0;
      loop_a = 1'b1; slave_a = 1'b0;
      start_b = 1'b0; tx_b = '0; cs_sel_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n",  cs_n_a, 1);
      check("rst_sclk",  sclk_a, 0);
      check("rst_busy",  busy_a, 0);
      check("rst_done",  done_a, 0);
      check("rst_rx",    rx_a,   0);
      check("rst_mosi",  mosi_a, 0);
      check("rst_cs_nb", cs_n_b, 32'hF);
      rst = 1'b0;
      @(posedge clk); #1;

      // Mode 0 loopback
      run_a(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0);
      check("m0_csn_accept",  r_csn0, 0);
      check("m0_busy_accept", r_busy0, 1);
      check("m0_rises",       r_rises, 8);
      check("m0_falls",       r_falls, 8);
      check("m0_latency",     r_lat, 72);
      check("m0_done_count",  r_done, 1);
      check("m0_busy_done",   r_busy_done, 0);
      check("m0_rx",          r_rx, 32'hA5);
      check("m0_cs_low",      r_cs_low, 71);
      check("m0_mosi_edges",  r_mosi_bad, 0);

      // Mode 3 with slave returning 0x3C
      run_a(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 0);
      check("m3_sclk_idle",   r_sclk0, 1);
      check("m3_mosi_seq",    r_mosi, 32'hC3);
      check("m3_mosi_edges",  r_mosi_bad, 0);
      check("m3_rises",       r_rises, 8);
      check("m3_rx",          r_rx, 32'h3C);
      check("m3_sclk_done",   r_sclk_done, 1);
      check("m3_latency",     r_lat, 72);

      // Back to mode 0 with a second start mid-transfer
      run_a(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 20);
      check("rs_sclk_cpol",   r_sclk0, 0);
      check("rs_rx",          r_rx, 32'h69);
      check("rs_done_count",  r_done, 1);
      check("rs_latency",     r_lat, 72);

      // Out-of-range chip select
      run_a(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0);
      check("cs_oob_accept",  r_csn0, 1);
      check("cs_oob_low",     r_cs_low, 0);
      check("cs_oob_done",    r_done, 1);
      check("cs_oob_rx",      r_rx, 32'h5A);

      // Reset at sclk edge 5
      tx_a = 8'hA5; cpol_a = 1'b0; cpha_a = 1'b0; cs_sel_a = 1'b0; loop_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      prev = sclk_a; edges = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (sclk_a != prev) edges++;
         prev = sclk_a;
         if (edges == 5) break;
      end
      check("rst_mid_edges", edges, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_cs_n", cs_n_a, 1);
      check("rst_mid_sclk", sclk_a, 0);
      check("rst_mid_busy", busy_a, 0);
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (done_a) cnt++;
      end
      check("rst_mid_no_done", cnt, 0);
      run_a(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0);
      check("rst_after_rx",   r_rx, 32'h3C);
      check("rst_after_done", r_done, 1);

      // Back-to-back words with start held high
      tx_a = 8'h11; cpol_a = 1'b0; cpha_a = 1'b0; cs_sel_a = 1'b0; loop_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      tx_a = 8'h22;
      got = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done_a) begin
            got = 1;
            break;
         end
      end
      check("b2b_done1",     got, 1);
      check("b2b_rx1",       rx_a, 32'h11);
      check("b2b_gap_high",  cs_n_a, 1);
      @(posedge clk); #1;
      start_a = 1'b0;
      check("b2b_gap_low",   cs_n_a, 0);
      check("b2b_busy2",     busy_a, 1);
      got = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done_a) begin
            got = 1;
            break;
         end
      end
      check("b2b_done2",     got, 1);
      check("b2b_rx2",       rx_a, 32'h22);

      // dut_b: 16-bit LSB first on chip select 2
      tx_b = 16'h8001; cs_sel_b = 2'd2; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      check("b_cs_n",  cs_n_b, 32'hB);
      check("b_busy",  busy_b, 1);
      prev = sclk_b; edges = 0; lat = -1; rec_b = '0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (sclk_b && !prev) begin
            if (edges < 16) rec_b[edges] = mosi_b;
            edges++;
         end
         prev = sclk_b;
         if (done_b) begin
            lat = c;
            break;
         end
      end
      check("b_latency",  lat, 34);
      check("b_rises",    edges, 16);
      check("b_mosi_seq", rec_b, 32'h8001);
      check("b_rx",       rx_b, 32'h8001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
